// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: buffers ALU and load results in per-source FIFOs,
// round-robins them onto one write port and tracks pending writes. Optional: WRITEBACK_STATS_EN.
module writeback_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [ADDRESS_WIDTH-1:0]    alu_id,
    input  logic [DATA_WIDTH-1:0]       alu_data,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [ADDRESS_WIDTH-1:0]    mem_id,
    input  logic [DATA_WIDTH-1:0]       mem_data,
    input  logic                        issue_en,
    input  logic [ADDRESS_WIDTH-1:0]    issue_id,
    output logic [2**ADDRESS_WIDTH-1:0] busy,
    output logic                        write_en,
    output logic [ADDRESS_WIDTH-1:0]    write_id,
    output logic [DATA_WIDTH-1:0]       write_data
`ifdef WRITEBACK_STATS_EN
    ,
    output logic [31:0]                 alu_write_count,
    output logic [31:0]                 mem_write_count,
    output logic [31:0]                 zero_drop_count
`endif
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int NREG = 2 ** ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0] alu_id_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    alu_data_q [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] mem_id_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    mem_data_q [FIFO_DEPTH];

    logic [PW:0]              alu_wptr, alu_rptr, mem_wptr, mem_rptr;
    logic                     alu_empty, alu_full, mem_empty, mem_full;
    logic                     alu_push, mem_push, pop_alu, pop_mem, pop_any;
    logic                     last_mem;
    logic [ADDRESS_WIDTH-1:0] pop_id;
    logic [DATA_WIDTH-1:0]    pop_data;
    logic [NREG-1:0]          busy_d;

    assign alu_empty = (alu_wptr == alu_rptr);
    assign mem_empty = (mem_wptr == mem_rptr);
    assign alu_full  = (alu_wptr[PW-1:0] == alu_rptr[PW-1:0]) && (alu_wptr[PW] != alu_rptr[PW]);
    assign mem_full  = (mem_wptr[PW-1:0] == mem_rptr[PW-1:0]) && (mem_wptr[PW] != mem_rptr[PW]);

    assign alu_ready = !rst && !alu_full;
    assign mem_ready = !rst && !mem_full;
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;

    // last_mem resets low so the first contested grant goes to mem.
    assign pop_alu = !alu_empty && (mem_empty || last_mem);
    assign pop_mem = !mem_empty && !pop_alu;
    assign pop_any = pop_alu || pop_mem;

    assign pop_id   = pop_alu ? alu_id_q[alu_rptr[PW-1:0]]   : mem_id_q[mem_rptr[PW-1:0]];
    assign pop_data = pop_alu ? alu_data_q[alu_rptr[PW-1:0]] : mem_data_q[mem_rptr[PW-1:0]];

    // A new issue to the same register outranks the retiring write.
    always_comb begin
        busy_d = busy;
        if (pop_any) busy_d[pop_id] = 1'b0;
        if (issue_en && (issue_id != '0)) busy_d[issue_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_id_q[alu_wptr[PW-1:0]]   <= alu_id;
            alu_data_q[alu_wptr[PW-1:0]] <= alu_data;
        end
        if (mem_push) begin
            mem_id_q[mem_wptr[PW-1:0]]   <= mem_id;
            mem_data_q[mem_wptr[PW-1:0]] <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_wptr   <= '0;
            alu_rptr   <= '0;
            mem_wptr   <= '0;
            mem_rptr   <= '0;
            last_mem   <= 1'b0;
            write_en   <= 1'b0;
            write_id   <= '0;
            write_data <= '0;
            busy       <= '0;
        end else begin
            if (alu_push) alu_wptr <= alu_wptr + 1'b1;
            if (mem_push) mem_wptr <= mem_wptr + 1'b1;
            if (pop_alu)  alu_rptr <= alu_rptr + 1'b1;
            if (pop_mem)  mem_rptr <= mem_rptr + 1'b1;
            if (pop_any) begin
                last_mem   <= pop_mem;
                write_id   <= pop_id;
                write_data <= pop_data;
            end
            write_en <= pop_any && (pop_id != '0);
            busy     <= busy_d;
        end
    end

`ifdef WRITEBACK_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_write_count <= '0;
            mem_write_count <= '0;
            zero_drop_count <= '0;
        end else if (pop_any) begin
            if (pop_id == '0)  zero_drop_count <= zero_drop_count + 32'd1;
            else if (pop_alu)  alu_write_count <= alu_write_count + 32'd1;
            else               mem_write_count <= mem_write_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: stimulus pushes expected writes per source,
// a negedge monitor retires them as write_en appears.
module tb_writeback_arbiter;
    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_en = 1'b0;
    logic [4:0]  alu_id = '0, mem_id = '0, issue_id = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, write_en;
    logic [4:0]  write_id;
    logic [31:0] write_data;
    logic [31:0] busy;
`ifdef WRITEBACK_STATS_EN
    logic [31:0] alu_write_count, mem_write_count, zero_drop_count;
`endif

    int total = 0;
    int bad   = 0;
    entry_t alu_q[$];
    entry_t mem_q[$];
    logic [4:0] obs_ids[$];

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_id     (alu_id),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_id     (mem_id),
        .mem_data   (mem_data),
        .issue_en   (issue_en),
        .issue_id   (issue_id),
        .busy       (busy),
        .write_en   (write_en),
        .write_id   (write_id),
        .write_data (write_data)
`ifdef WRITEBACK_STATS_EN
        ,
        .alu_write_count (alu_write_count),
        .mem_write_count (mem_write_count),
        .zero_drop_count (zero_drop_count)
`endif
    );

    // Monitor: every write must match the head of one source's expected queue.
    always @(negedge clk) begin
        if (write_en) begin
            total++;
            obs_ids.push_back(write_id);
            if (alu_q.size() > 0 && alu_q[0].id == write_id && alu_q[0].data == write_data)
                void'(alu_q.pop_front());
            else if (mem_q.size() > 0 && mem_q[0].id == write_id && mem_q[0].data == write_data)
                void'(mem_q.pop_front());
            else begin
                bad++;
                $display("FAIL wb_write: got id=%0d data=%h, required a head of alu/mem queue",
                         write_id, write_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // One clock: drive at negedge+1, sample acceptance, return at next negedge+1.
    task automatic cyc(input logic av, input logic [4:0] aid, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mid, input logic [31:0] md,
                       input logic ie, input logic [4:0] iid,
                       output logic a_acc, output logic m_acc);
        entry_t e;
        alu_valid = av; alu_id = aid; alu_data = ad;
        mem_valid = mv; mem_id = mid; mem_data = md;
        issue_en  = ie; issue_id = iid;
        a_acc = av && alu_ready;
        m_acc = mv && mem_ready;
        if (a_acc && aid != 5'd0) begin e.id = aid; e.data = ad; alu_q.push_back(e); end
        if (m_acc && mid != 5'd0) begin e.id = mid; e.data = md; mem_q.push_back(e); end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        logic a, m;
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a, m);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (alu_q.size() + mem_q.size()) > 0; i++) idle();
        chk(name, 64'(alu_q.size() + mem_q.size()), 64'd0);
    endtask

    initial begin
        logic a, m;
        logic saw_full;
        int   ai, mi, a_cnt, m_cnt;
        logic [4:0] exp3 [8];

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        chk("rst_mem_ready", 64'(mem_ready), 64'd0);
        chk("rst_write_en", 64'(write_en), 64'd0);
        chk("rst_write_id", 64'(write_id), 64'd0);
        chk("rst_write_data", 64'(write_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        chk("alu_ready_after_rst", 64'(alu_ready), 64'd1);

        // Single ALU push: write visible only in the cycle after the second edge
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a, m);
        chk("t1_accept", 64'(a), 64'd1);
        chk("t1_we_edge1", 64'(write_en), 64'd0);
        idle();
        chk("t1_we_edge2", 64'(write_en), 64'd1);
        chk("t1_id_edge2", 64'(write_id), 64'd5);
        chk("t1_data_edge2", 64'(write_data), 64'hDEADBEEF);
        chk("t1_ready", 64'(alu_ready), 64'd1);
        idle();
        chk("t1_we_edge3", 64'(write_en), 64'd0);

        // Back-to-back ALU stream never fills the FIFO
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a, m);
            chk("t2_accept", 64'(a), 64'd1);
        end
        drain("t2_drain");

        // Contested heads alternate, mem first
        obs_ids.delete();
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 5'(i), 32'hA0 + 32'(i), 1'b1, 5'(10 + i), 32'hB0 + 32'(i),
                1'b0, 5'd0, a, m);
        drain("t3_drain");
        exp3 = '{5'd11, 5'd1, 5'd12, 5'd2, 5'd13, 5'd3, 5'd14, 5'd4};
        chk("t3_count", 64'(obs_ids.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < obs_ids.size()) chk("t3_order", 64'(obs_ids[i]), 64'(exp3[i]));

        // Both sources streaming for 8 cycles: mem fills, nothing lost or duplicated
        saw_full = 1'b0; ai = 0; mi = 0; a_cnt = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 5'(16 + ai), 32'hC000 + 32'(ai), 1'b1, 5'(20 + mi), 32'hD000 + 32'(mi),
                1'b0, 5'd0, a, m);
            if (a) begin ai++; a_cnt++; end
            if (m) begin mi++; m_cnt++; end
            else saw_full = 1'b1;
        end
        chk("t4_mem_ready_low", 64'(saw_full), 64'd1);
        chk("t4_mem_accepts", 64'(m_cnt), 64'd7);
        chk("t4_alu_accepts", 64'(a_cnt), 64'd7);
        drain("t4_drain");

        // Scoreboard set/clear
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, a, m);
        chk("t5_busy_set", 64'(busy), 64'h80);
        idle(); idle();
        chk("t5_busy_hold", 64'(busy[7]), 64'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, a, m);
        chk("t5_busy_push", 64'(busy[7]), 64'd1);
        idle();
        chk("t5_we_pop", 64'(write_en), 64'd1);
        chk("t5_busy_clear", 64'(busy[7]), 64'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, a, m);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, a, m);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, a, m);
        chk("t5_we_pop2", 64'(write_en), 64'd1);
        chk("t5_set_wins", 64'(busy[7]), 64'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h79, 1'b0, 5'd0, a, m);
        idle();
        chk("t5_busy_final", 64'(busy), 64'd0);
        drain("t5_drain");

        // Register 0 writes are absorbed; busy[0] never set
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, a, m);
        cyc(1'b1, 5'd0, 32'h5A, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, a, m);
        chk("t6_accept_zero", 64'(a), 64'd1);
        idle();
        chk("t6_we_zero", 64'(write_en), 64'd0);
        idle();
        chk("t6_busy", 64'(busy), 64'h8);
`ifdef WRITEBACK_STATS_EN
        chk("t6_zero_drops", 64'(zero_drop_count), 64'd1);
        chk("t6_alu_writes", 64'(alu_write_count), 64'd17);
        chk("t6_mem_writes", 64'(mem_write_count), 64'd14);
`endif

        // Reset with three entries still queued discards them
        cyc(1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0, 1'b0, 5'd0, a, m);
        cyc(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd9, a, m);
        rst = 1'b1;
        alu_q.delete();
        mem_q.delete();
        #1;
        chk("t7_ready_in_rst", 64'({alu_ready, mem_ready}), 64'd0);
        idle(); idle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) idle();
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_we", 64'(write_en), 64'd0);
        chk("t7_ready", 64'({alu_ready, mem_ready}), 64'h3);
`ifdef WRITEBACK_STATS_EN
        chk("t7_stats", 64'(alu_write_count | mem_write_count | zero_drop_count), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
